// File: rtl/act_pkg.sv
// Shared definitions for the activation stage: mode codes, FSM states and
// the beat-count helper used to size the sequencing counter.
package act_pkg;

  localparam logic [1:0] ACT_IDENT = 2'b00;
  localparam logic [1:0] ACT_RELU  = 2'b01;
  localparam logic [1:0] ACT_LEAKY = 2'b10;
  localparam logic [1:0] ACT_CLIP  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } act_state_t;

  function automatic int beat_count(input int nodes, input int lanes);
    return nodes / lanes;
  endfunction

endpackage

// File: rtl/act_lane.sv
// Single-element activation function, purely combinational.
// One instance per lane; the top replicates it LANES times.
module act_lane
  import act_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic signed [DATA_WIDTH-1:0] x,
  input  logic        [1:0]            mode,
  input  logic signed [DATA_WIDTH-1:0] clip,
  output logic signed [DATA_WIDTH-1:0] y
);

  logic x_neg;
  logic clip_neg;

  assign x_neg    = x[DATA_WIDTH-1];
  assign clip_neg = clip[DATA_WIDTH-1];

  // The arithmetic shift floors toward -inf and can never overflow, even for
  // the most-negative input, because it only moves bits toward the LSB.
  always_comb begin
    y = x;
    case (mode)
      ACT_IDENT: y = x;
      ACT_RELU:  if (x_neg) y = '0;
      ACT_LEAKY: if (x_neg) y = x >>> LEAKY_SHIFT;
      ACT_CLIP: begin
        if (clip_neg || x_neg) y = '0;
        else if (x > clip)     y = clip;
      end
      default:   y = x;
    endcase
  end

endmodule

// File: rtl/activation_unit_seq.sv
// Sequential multi-mode activation stage: walks a NODES-element vector LANES
// elements per clock, with a start/busy/done handshake toward the layer controller.
module activation_unit_seq
  import act_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int NODES       = 256,
  parameter int LANES       = 8,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [1:0]                  mode,
  input  logic [DATA_WIDTH-1:0]       clip_max,
  input  logic [DATA_WIDTH*NODES-1:0] input_vec,
  output logic [DATA_WIDTH*NODES-1:0] output_vec,
  output logic                        busy,
  output logic                        done_flag
);

  localparam int BEATS   = beat_count(NODES, LANES);
  localparam int CNT_W   = $clog2(BEATS) + 1;
  localparam int SLICE_W = DATA_WIDTH * LANES;
  localparam int VEC_W   = DATA_WIDTH * NODES;
  localparam int IDX_W   = (VEC_W > 1) ? $clog2(VEC_W) : 1;

  if (NODES % LANES != 0) begin : g_bad_lanes
    $error("activation_unit_seq: NODES must be a multiple of LANES");
  end
  if (LANES < 1 || LANES > NODES) begin : g_bad_lane_count
    $error("activation_unit_seq: LANES must lie in 1..NODES");
  end
  if (LEAKY_SHIFT < 1 || LEAKY_SHIFT > DATA_WIDTH - 1) begin : g_bad_shift
    $error("activation_unit_seq: LEAKY_SHIFT must lie in 1..DATA_WIDTH-1");
  end

  act_state_t             state;
  act_state_t             state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [1:0]             mode_r;
  logic [DATA_WIDTH-1:0]  clip_r;
  logic [IDX_W-1:0]       base;
  logic [SLICE_W-1:0]     beat_in;
  logic [SLICE_W-1:0]     beat_out;
  logic                   accept;
  logic                   last_beat;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // A start is only honoured from IDLE or DONE; a start during RUN is dropped.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done_flag = 1'b0;
    last_beat = (cnt == CNT_W'(BEATS - 1));
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_beat) state_nxt = DONE;
      end
      DONE: begin
        done_flag = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Once the counter passes the last beat the slice base parks at zero so the
  // select never reaches past the end of the vector.
  always_comb begin
    base = '0;
    if (int'(cnt) < BEATS) base = IDX_W'(int'(cnt) * SLICE_W);
  end

  assign beat_in = input_vec[base +: SLICE_W];

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    act_lane #(
      .DATA_WIDTH  (DATA_WIDTH),
      .LEAKY_SHIFT (LEAKY_SHIFT)
    ) u_lane (
      .x    (beat_in[j*DATA_WIDTH +: DATA_WIDTH]),
      .mode (mode_r),
      .clip (clip_r),
      .y    (beat_out[j*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Mode and ceiling are frozen at accept so upstream may change them mid-run.
  always_ff @(posedge clk) begin
    if (!reset) begin
      output_vec <= '0;
      cnt        <= '0;
      mode_r     <= ACT_IDENT;
      clip_r     <= '0;
    end else if (accept) begin
      output_vec <= '0;
      cnt        <= '0;
      mode_r     <= mode;
      clip_r     <= clip_max;
    end else if (state == RUN) begin
      output_vec[base +: SLICE_W] <= beat_out;
      cnt                         <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_activation_unit_seq.sv
// Self-checking bench for activation_unit_seq: default config plus the
// NODES=LANES=4 and NODES=12/LANES=3 configurations, checked against a reference model.
module tb_activation_unit_seq;
  import act_pkg::*;

  localparam int DW      = 16;
  localparam int N0      = 256;
  localparam int BEATS0  = 32;
  localparam int LEAKY_D = 8;
  localparam int BOUND   = 200;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic              start0 = 1'b0;
  logic [1:0]        mode0 = 2'b00;
  logic [DW-1:0]     clip0 = '0;
  logic [DW*N0-1:0]  in0 = '0;
  logic [DW*N0-1:0]  out0;
  logic              busy0, done0;

  logic              start_s = 1'b0;
  logic [1:0]        mode_s = 2'b00;
  logic [DW-1:0]     clip_s = '0;
  logic [DW*4-1:0]   ina = '0;
  logic [DW*4-1:0]   outa;
  logic [DW*12-1:0]  inb = '0;
  logic [DW*12-1:0]  outb;
  logic              busya, donea, busyb, doneb;

  int n_cmp = 0;
  int n_bad = 0;

  activation_unit_seq #(.DATA_WIDTH(DW), .NODES(N0), .LANES(8), .LEAKY_SHIFT(3)) dut (
    .clk(clk), .reset(reset), .start(start0), .mode(mode0), .clip_max(clip0),
    .input_vec(in0), .output_vec(out0), .busy(busy0), .done_flag(done0)
  );

  activation_unit_seq #(.DATA_WIDTH(DW), .NODES(4), .LANES(4), .LEAKY_SHIFT(3)) dut_a (
    .clk(clk), .reset(reset), .start(start_s), .mode(mode_s), .clip_max(clip_s),
    .input_vec(ina), .output_vec(outa), .busy(busya), .done_flag(donea)
  );

  activation_unit_seq #(.DATA_WIDTH(DW), .NODES(12), .LANES(3), .LEAKY_SHIFT(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_s), .mode(mode_s), .clip_max(clip_s),
    .input_vec(inb), .output_vec(outb), .busy(busyb), .done_flag(doneb)
  );

  // Reference activation in plain integer arithmetic; leaky uses floor division.
  function automatic logic [DW-1:0] ref_act(input logic [DW-1:0] xb, input logic [1:0] m,
                                            input logic [DW-1:0] cb);
    int x, c, y;
    x = int'($signed(xb));
    c = int'($signed(cb));
    case (m)
      2'd0:    y = x;
      2'd1:    y = (x < 0) ? 0 : x;
      2'd2:    y = (x < 0) ? (x - (LEAKY_D - 1)) / LEAKY_D : x;
      default: y = (c < 0) ? 0 : ((x < 0) ? 0 : ((x > c) ? c : x));
    endcase
    return y[DW-1:0];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic checkVector(input string name, input logic [DW*N0-1:0] act,
                             input logic [DW*N0-1:0] exp, input int n);
    int bad = 0;
    int first = -1;
    for (int i = 0; i < n; i++) begin
      if (act[i*DW +: DW] !== exp[i*DW +: DW]) begin
        if (first < 0) first = i;
        bad++;
      end
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("[TB] FAIL %s: %0d elements wrong, elem %0d got %0h want %0h", name, bad, first,
               act[first*DW +: DW], exp[first*DW +: DW]);
    end
  endtask

  function automatic logic [DW*N0-1:0] model_vec(input logic [DW*N0-1:0] xin, input int n,
                                                 input logic [1:0] m, input logic [DW-1:0] c);
    logic [DW*N0-1:0] r = '0;
    for (int i = 0; i < n; i++) r[i*DW +: DW] = ref_act(xin[i*DW +: DW], m, c);
    return r;
  endfunction

  // Pulses start on the default instance, scrambles mode/clip after accept,
  // optionally re-pulses start mid-run, and measures busy length and done edge.
  task automatic applyStimulus(input logic [1:0] m, input logic [DW-1:0] c, input int inject_at,
                               output int busy_cycles, output int done_edge, output logic first_ok);
    @(negedge clk);
    mode0  = m;
    clip0  = c;
    start0 = 1'b1;
    @(negedge clk);
    start0      = 1'b0;
    mode0       = ~m;
    clip0       = ~c;
    busy_cycles = 0;
    done_edge   = -1;
    first_ok    = 1'b0;
    for (int e = 0; e < BOUND; e++) begin
      if (e == 0) first_ok = busy0 && !done0;
      if (done0) begin
        done_edge = e;
        break;
      end
      if (busy0) busy_cycles++;
      start0 = (e == inject_at);
      if (e == inject_at) mode0 = ACT_IDENT;
      @(negedge clk);
    end
    start0 = 1'b0;
  endtask

  function automatic logic [DW*N0-1:0] random_vec();
    logic [DW*N0-1:0] v;
    for (int i = 0; i < N0; i++) v[i*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  typedef struct {
    logic [1:0]    m;
    logic [DW-1:0] c;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    string         name;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int bc, de;
    logic fok;
    logic [DW*N0-1:0] relu_in, relu_exp;

    tbl[0]  = '{ACT_LEAKY, 16'h0000, 16'hFFF0, 16'hFFFE, "leaky_m16"};
    tbl[1]  = '{ACT_LEAKY, 16'h0000, 16'hFFFF, 16'hFFFF, "leaky_m1"};
    tbl[2]  = '{ACT_LEAKY, 16'h0000, 16'h8000, 16'hF000, "leaky_min"};
    tbl[3]  = '{ACT_LEAKY, 16'h0000, 16'd100,  16'd100,  "leaky_100"};
    tbl[4]  = '{ACT_CLIP,  16'h0600, 16'h0800, 16'h0600, "clip_high"};
    tbl[5]  = '{ACT_CLIP,  16'h0600, 16'h0300, 16'h0300, "clip_mid"};
    tbl[6]  = '{ACT_CLIP,  16'h0600, 16'hFF00, 16'h0000, "clip_neg"};
    tbl[7]  = '{ACT_CLIP,  16'hFFFF, 16'h0300, 16'h0000, "clip_negceil"};
    tbl[8]  = '{ACT_CLIP,  16'h0600, 16'h0600, 16'h0600, "clip_equal"};
    tbl[9]  = '{ACT_RELU,  16'h0000, 16'h7FFF, 16'h7FFF, "relu_max"};
    tbl[10] = '{ACT_RELU,  16'h0000, 16'h8000, 16'h0000, "relu_min"};
    tbl[11] = '{ACT_IDENT, 16'h0000, 16'h8000, 16'h8000, "ident_min"};

    for (int i = 0; i < N0; i++) begin
      relu_in[i*DW +: DW]  = (i % 2 == 1) ? DW'(-i) : DW'(i);
      relu_exp[i*DW +: DW] = (i % 2 == 1) ? DW'(0) : DW'(i);
    end

    repeat (3) @(negedge clk);
    checkOutput("reset_out", 64'(out0 != '0), 64'd0);
    checkOutput("reset_busy", 64'(busy0), 64'd0);
    checkOutput("reset_done", 64'(done0), 64'd0);
    reset = 1'b1;

    in0 = relu_in;
    applyStimulus(ACT_RELU, '0, -1, bc, de, fok);
    checkOutput("relu_busy_len", 64'(bc), 64'(BEATS0));
    checkOutput("relu_done_edge", 64'(de), 64'(BEATS0));
    checkVector("relu_pattern", out0, relu_exp, N0);
    repeat (3) @(negedge clk);
    checkOutput("done_sticky", 64'({busy0, done0}), 64'b01);

    in0 = random_vec();
    applyStimulus(ACT_IDENT, '0, -1, bc, de, fok);
    checkOutput("restart_from_done", 64'(fok), 64'd1);
    checkVector("ident_unchanged", out0, in0, N0);

    in0 = relu_in;
    applyStimulus(ACT_RELU, '0, 5, bc, de, fok);
    checkOutput("busy_start_len", 64'(bc), 64'(BEATS0));
    checkVector("busy_start_ignored", out0, relu_exp, N0);

    @(negedge clk);
    mode0  = ACT_RELU;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midrun_reset", 64'({busy0, done0, (out0 != '0)}), 64'd0);
    reset = 1'b1;
    applyStimulus(ACT_RELU, '0, -1, bc, de, fok);
    checkOutput("after_reset_done_edge", 64'(de), 64'(BEATS0));
    checkVector("after_reset_relu", out0, relu_exp, N0);

    for (int t = 0; t < 12; t++) begin
      in0 = random_vec();
      in0[0 +: DW]          = tbl[t].x;
      in0[(N0-1)*DW +: DW]  = tbl[t].x;
      applyStimulus(tbl[t].m, tbl[t].c, -1, bc, de, fok);
      checkOutput({tbl[t].name, "_e0"}, 64'(out0[0 +: DW]), 64'(tbl[t].y));
      checkOutput({tbl[t].name, "_elast"}, 64'(out0[(N0-1)*DW +: DW]), 64'(tbl[t].y));
      checkVector({tbl[t].name, "_vec"}, out0, model_vec(in0, N0, tbl[t].m, tbl[t].c), N0);
    end

    for (int r = 0; r < 6; r++) begin
      logic [1:0]    m;
      logic [DW-1:0] c;
      m   = 2'($urandom_range(0, 3));
      c   = (r == 5) ? 16'h8000 : DW'($urandom);
      in0 = random_vec();
      applyStimulus(m, c, -1, bc, de, fok);
      checkOutput("rand_busy_len", 64'(bc), 64'(BEATS0));
      checkVector("rand_vec", out0, model_vec(in0, N0, m, c), N0);
    end

    for (int m = 0; m < 4; m++) begin
      int ca, cb;
      logic [DW*N0-1:0] xa, xb;
      xa = random_vec();
      xb = random_vec();
      ina    = xa[DW*4-1:0];
      inb    = xb[DW*12-1:0];
      ina[0 +: DW] = 16'h8000;
      inb[0 +: DW] = 16'hFFFF;
      @(negedge clk);
      mode_s  = 2'(m);
      clip_s  = DW'($urandom_range(0, 16'h0800));
      start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      ca = 0;
      cb = 0;
      for (int e = 0; e < 20 && !(donea && doneb); e++) begin
        if (busya) ca++;
        if (busyb) cb++;
        @(negedge clk);
      end
      checkOutput("cfg4_busy_len", 64'(ca), 64'd1);
      checkOutput("cfg12_busy_len", 64'(cb), 64'd4);
      checkVector("cfg4_vec", (DW*N0)'(outa), model_vec((DW*N0)'(ina), 4, mode_s, clip_s), 4);
      checkVector("cfg12_vec", (DW*N0)'(outb), model_vec((DW*N0)'(inb), 12, mode_s, clip_s), 12);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/activation_unit_seq.md
Name: activation_unit_seq

Overview:
- Sequential, multi-mode activation stage that sits after the fully-connected and conv accumulators in the 1D-CNN datapath.
- Processes a flat vector of NODES signed fixed-point values, LANES elements per clock.
- Supports identity, ReLU, leaky ReLU and clipped ReLU.
- Uses a start/busy/done handshake so the upstream layer controller can sequence layers.

Parameters:
DATA_WIDTH, 16, element width, signed two's complement
NODES, 256, number of elements in the vector; must be a multiple of LANES
LANES, 8, elements processed per clock; 1 <= LANES <= NODES
LEAKY_SHIFT, 3, leaky-ReLU slope = 2^-LEAKY_SHIFT; range 1..DATA_WIDTH-1

Ports:
clk  input  1  clock, rising-edge
reset  input  1  synchronous, active-low
start  input  1  one-cycle request to process input_vec
mode  input  2  activation select, sampled on accepted start
clip_max  input  DATA_WIDTH  signed ceiling for clipped ReLU, sampled on accepted start
input_vec  input  DATA_WIDTH*NODES  element i at bits [DATA_WIDTH*i +: DATA_WIDTH]
output_vec  output  DATA_WIDTH*NODES  results, same packing
busy  output  1  high while processing
done_flag  output  1  sticky completion flag

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, output_vec=0, busy=0, done_flag=0, beat counter=0, mode_r=0, clip_r=0. Reset overrides everything, including mid-RUN; no partial results are retained.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1:
  - latch mode into mode_r and clip_max into clip_r
  - clear output_vec to 0 and counter to 0
  - go to RUN, busy=1
- RUN, beat k (k = 0 .. NODES/LANES-1):
  - elements k*LANES .. k*LANES+LANES-1 are read from input_vec and registered into output_vec the same edge
  - counter increments
  - on the last beat go to DONE
- DONE: busy=0, done_flag=1. done_flag stays high until the next accepted start or reset.
- DONE, start=1: same action as in IDLE; done_flag clears on that edge.
- Latency: start accepted at edge 0; busy high for exactly NODES/LANES cycles; done_flag rises at edge NODES/LANES. Default config = 32 cycles.
- start while busy=1: ignored, no effect on counter or latched mode.
- input_vec must be held stable while busy=1; only the current beat's slice is sampled.
- mode and clip_max changes while busy have no effect.
- Per-element function, x signed, DATA_WIDTH bits:
  - 2'b00 identity: y=x
  - 2'b01 ReLU: y = (x<0) ? 0 : x
  - 2'b10 leaky: y = (x<0) ? (x >>> LEAKY_SHIFT) : x. Arithmetic shift, rounds toward -inf; most-negative input must not overflow.
  - 2'b11 clipped: y = min(max(x,0), clip_r), signed compare; if clip_r<0 then y=0.
- Counter width: $clog2(NODES/LANES)+1 bits. When NODES==LANES, RUN lasts one cycle.
- Elaboration check: NODES % LANES != 0 must fail at elaboration (generate-time error).

Decomposition:
- Package act_pkg:
  - mode localparams ACT_IDENT=2'b00, ACT_RELU=2'b01, ACT_LEAKY=2'b10, ACT_CLIP=2'b11
  - state encoding IDLE/RUN/DONE
  - helper function for beat count NODES/LANES
- Sub-module act_lane: purely combinational single-element activation. Inputs: x, mode, clip; parameters DATA_WIDTH, LEAKY_SHIFT. Instantiated LANES times via generate.
- Top module activation_unit_seq holds the FSM, counter, and output register write-back with an indexed part-select per beat.

Test Plan:
- Reset: assert reset=0 mid-RUN at beat 10 -> next cycle busy=0, done_flag=0, output_vec=0; a fresh start then completes in 32 cycles.
- ReLU, default params, element i = (i odd ? -i : i) -> after done, odd elements 0, even elements = i; busy high exactly 32 cycles, done_flag rises at edge 32.
- Leaky, LEAKY_SHIFT=3:
  - x=-16 -> -2
  - x=-1 -> -1
  - x=16'h8000 -> 16'hF000
  - x=100 -> 100
- Clipped, clip_max=16'h0600 (6.0 Q8.8):
  - inputs 16'h0800 -> 16'h0600
  - 16'h0300 -> 16'h0300
  - 16'hFF00 -> 0
  - with clip_max=-1, all outputs 0.
- Handshake:
  - start pulsed at beat 5 with mode=00 -> ignored, results still ReLU
  - start while in DONE -> done_flag clears same edge, new run begins
  - identity mode returns input_vec unchanged
- Config sweep NODES=LANES=4, then NODES=12/LANES=3 -> busy lasts 1 and 4 cycles respectively, results correct for all modes.
